dff_load_arbiter: RTL and testbench

Round-robin arbiter that shares one load-enabled data register bank (D flip-flops with `load`/`data_in`) among `N_REQ` requesters. It samples requests, selects one winner per arbitration, and drives the bank's `load` and `data_in` for exactly the granted cycles. It acknowledges the winner with a one-cycle grant. It sits between the requester logic and the shared register bank and is the only driver of that bank's load path.

---
 rtl/dff_arb_pkg.sv | 16 +
 rtl/dff_load_arbiter_rr_pick.sv | 26 ++
 rtl/dff_load_arbiter.sv | 122 ++++++++++++
 tb/tb_dff_load_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared types, constants and helpers for the load arbiter
package dff_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int BURST_CNT_W = 8;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_load_arbiter_rr_pick.sv
// rtl/dff_load_arbiter_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    // Scan from the farthest candidate back to ptr so the nearest requester at or after ptr wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                valid  = 1'b1;
                winner = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/dff_load_arbiter.sv
// rtl/dff_load_arbiter.sv - round-robin owner of a shared register bank load path (optional burst lock: DFF_ARB_LOCK_EN)
module dff_load_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int IW       = idx_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      reg_load,
    output logic [DATA_W-1:0]         reg_data,
    output logic [IW-1:0]             owner,
    output logic                      busy
);

    state_t                 state;
    state_t                 state_nx;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          ptr_nx;
    logic [IW-1:0]          owner_nx;
    logic [IW-1:0]          owner_inc;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   stay;
    logic                   load_nx;
    logic                   busy_nx;
    logic [N_REQ-1:0]       gnt_nx;
    logic [DATA_W-1:0]      data_nx;
    logic [DATA_W-1:0]      pick_word;
    logic [DATA_W-1:0]      owner_word;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] burst_nx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign pick_word  = req_data[int'(pick_idx) * DATA_W +: DATA_W];
    assign owner_word = req_data[int'(owner) * DATA_W +: DATA_W];
    assign owner_inc  = IW'((int'(owner) + 1) % N_REQ);

`ifdef DFF_ARB_LOCK_EN
    assign stay = lock[owner] && req[owner] && (burst_cnt < BURST_CNT_W'(MAX_BURST));
`else
    wire unused_lock = ^lock;
    assign stay = 1'b0;
`endif

    // Next-state and next-output decode; outputs are only ever taken from registers.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        gnt_nx   = gnt;
        load_nx  = reg_load;
        busy_nx  = busy;
        data_nx  = reg_data;
        burst_nx = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx = ST_GRANT;
                    owner_nx = pick_idx;
                    gnt_nx   = N_REQ'(1) << pick_idx;
                    load_nx  = 1'b1;
                    busy_nx  = 1'b1;
                    data_nx  = pick_word;
                    burst_nx = BURST_CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (stay) begin
                    data_nx  = owner_word;
                    burst_nx = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                    gnt_nx   = '0;
                    load_nx  = 1'b0;
                    busy_nx  = 1'b0;
                    ptr_nx   = owner_inc;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending load immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            reg_load  <= 1'b0;
            busy      <= 1'b0;
            reg_data  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            gnt       <= gnt_nx;
            reg_load  <= load_nx;
            busy      <= busy_nx;
            reg_data  <= data_nx;
            burst_cnt <= burst_nx;
        end
    end

endmodule

// File: tb/tb_dff_load_arbiter.sv
// tb/tb_dff_load_arbiter.sv - randomized and directed self-checking bench for dff_load_arbiter
module tb_dff_load_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
`ifdef DFF_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           reg_load;
    logic [W-1:0]   reg_data;
    logic [1:0]     owner;
    logic           busy;

    dff_load_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .req_data (req_data),
        .gnt      (gnt),
        .reg_load (reg_load),
        .reg_data (reg_data),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one owner at a time, ptr advances past the owner on release.
    bit         m_grant = 1'b0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_burst = 0;
    logic [W-1:0] m_data = '0;

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        int best;
        int bestd;
        best  = 0;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - p + N) % N) < bestd) begin
                bestd = (i - p + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_grant <= 1'b0;
            m_owner <= 0;
            m_ptr   <= 0;
            m_burst <= 0;
            m_data  <= '0;
        end else if (!m_grant) begin
            if (req != '0) begin
                m_grant <= 1'b1;
                m_owner <= rr_winner(req, m_ptr);
                m_data  <= req_data[rr_winner(req, m_ptr) * W +: W];
                m_burst <= 1;
            end
        end else if (LOCK_EN && lock[m_owner] && req[m_owner] && m_burst < MB) begin
            m_data  <= req_data[m_owner * W +: W];
            m_burst <= m_burst + 1;
        end else begin
            m_grant <= 1'b0;
            m_ptr   <= (m_owner + 1) % N;
        end
    end

    // Load log of what the bank actually captured.
    int           log_own[$];
    logic [W-1:0] log_dat[$];
    int           log_cyc[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        exp_gnt = m_grant ? (4'b0001 << m_owner) : 4'b0000;
        check("gnt", gnt, exp_gnt);
        check("reg_load", reg_load, m_grant);
        check("busy", busy, m_grant);
        check("reg_data", reg_data, m_data);
        check("owner", owner, m_owner);
        check("load_is_or_gnt", reg_load, |gnt);
        check("gnt_onehot0", $onehot0(gnt), 1'b1);
        if (reg_load) begin
            log_own.push_back(int'(owner));
            log_dat.push_back(reg_data);
            log_cyc.push_back(cyc);
        end
    end

    // Requester agents.
    int           pend[N];
    int           widx[N];
    int           hold[N];
    int           gap[N];
    bit           lockr[N];
    logic [W-1:0] words[N][16];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_data[i * W +: W] = words[i][widx[i]];
            lock[i]              = lockr[i];
        end
    endtask

    task automatic agents_step();
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                widx[i]++;
                pend[i]--;
                if (!(lockr[i] && pend[i] > 0)) begin
                    req[i]  = 1'b0;
                    hold[i] = gap[i];
                end
            end else if (!req[i] && pend[i] > 0) begin
                if (hold[i] > 0) hold[i]--;
                else req[i] = 1'b1;
            end
        end
        drive();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        agents_step();
    endtask

    task automatic start_req(input int i, input int n, input bit lk, input int g);
        pend[i]  = n;
        widx[i]  = 0;
        lockr[i] = lk;
        gap[i]   = g;
        hold[i]  = 0;
        req[i]   = 1'b1;
        drive();
    endtask

    task automatic clear_agents();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; widx[i] = 0; hold[i] = 0; gap[i] = 0; lockr[i] = 1'b0;
            req[i]  = 1'b0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_agents();
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic clear_log();
        log_own.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    initial begin
        int e_own[6];
        logic [W-1:0] e_dat[6];
        int e_gap[5];
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 16; k++) words[i][k] = '0;
        clear_agents();

        // Reset state.
        do_reset();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_load", reg_load, 1'b0);
        check("rst_data", reg_data, 8'h00);
        check("rst_owner", owner, 2'd0);
        check("rst_busy", busy, 1'b0);

        // Single requester.
        words[1][0] = 8'hA5;
        start_req(1, 1, 1'b0, 1);
        cycle();
        check("single_gnt", gnt, 4'b0010);
        check("single_load", reg_load, 1'b1);
        check("single_data", reg_data, 8'hA5);
        cycle();
        check("single_gnt_end", gnt, 4'b0000);
        check("single_load_end", reg_load, 1'b0);
        check("single_data_hold", reg_data, 8'hA5);
        check("single_owner_hold", owner, 2'd1);
        check("single_ptr", m_ptr, 2);

        // Wrap-around: grant 2 to move ptr to 3, then 1001.
        words[2][0] = 8'h42;
        start_req(2, 1, 1'b0, 1);
        repeat (3) cycle();
        clear_log();
        words[0][0] = 8'h10;
        words[3][0] = 8'h30;
        start_req(0, 1, 1'b0, 1);
        start_req(3, 1, 1'b0, 1);
        repeat (6) cycle();
        check("wrap_n", log_own.size(), 2);
        if (log_own.size() >= 2) begin
            check("wrap_first", log_own[0], 3);
            check("wrap_first_data", log_dat[0], 8'h30);
            check("wrap_second", log_own[1], 0);
            check("wrap_second_data", log_dat[1], 8'h10);
        end

        // Reset asserted during GRANT.
        words[1][0] = 8'h3C;
        start_req(1, 1, 1'b0, 1);
        cycle();
        check("midrst_pre_gnt", gnt, 4'b0010);
        #2 rst = 1'b0;
        #1;
        check("midrst_gnt", gnt, 4'b0000);
        check("midrst_load", reg_load, 1'b0);
        check("midrst_data", reg_data, 8'h00);
        check("midrst_owner", owner, 2'd0);
        check("midrst_busy", busy, 1'b0);
        clear_agents();
        cycle();
        rst = 1'b1;
        words[2][0] = 8'h5A;
        start_req(2, 1, 1'b0, 1);
        cycle();
        check("postrst_gnt", gnt, 4'b0100);
        check("postrst_data", reg_data, 8'h5A);
        repeat (3) cycle();

        // Fairness with all four requesting.
        do_reset();
        clear_log();
        for (int i = 0; i < N; i++) begin
            words[i][0] = W'(8'h10 * i + 1);
            words[i][1] = W'(8'h10 * i + 2);
            start_req(i, 2, 1'b0, 1);
        end
        repeat (20) cycle();
        check("fair_n", log_own.size(), 8);
        if (log_own.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("fair_order", log_own[k], k % 4);
            for (int k = 0; k < 4; k++) check("fair_spacing", log_cyc[k + 1] - log_cyc[k], 2);
        end

        // Burst lock stimulus.
        do_reset();
        clear_log();
        words[1][0] = 8'h11; words[1][1] = 8'h22; words[1][2] = 8'h33;
        words[1][3] = 8'h44; words[1][4] = 8'h55;
        words[2][0] = 8'h77;
        start_req(1, 5, 1'b1, 1);
        start_req(2, 1, 1'b0, 1);
        repeat (20) cycle();
`ifdef DFF_ARB_LOCK_EN
        e_own = '{1, 1, 1, 1, 2, 1};
        e_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77, 8'h55};
        e_gap = '{1, 1, 1, 2, 2};
`else
        e_own = '{1, 2, 1, 1, 1, 1};
        e_dat = '{8'h11, 8'h77, 8'h22, 8'h33, 8'h44, 8'h55};
        e_gap = '{2, 2, 2, 2, 2};
`endif
        check("lock_n", log_own.size(), 6);
        if (log_own.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                check("lock_owner", log_own[k], e_own[k]);
                check("lock_data", log_dat[k], e_dat[k]);
            end
            for (int k = 0; k < 5; k++) check("lock_spacing", log_cyc[k + 1] - log_cyc[k], e_gap[k]);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] == 0 && !req[i] && !gnt[i] && $urandom_range(7, 0) == 0) begin
                    for (int k = 0; k < 16; k++) words[i][k] = W'($urandom);
                    start_req(i, $urandom_range(6, 1), 1'($urandom_range(1, 0)), $urandom_range(2, 0));
                end else if (req[i] && !gnt[i] && $urandom_range(31, 0) == 0) begin
                    req[i]  = 1'b0;
                    pend[i] = 0;
                end
            end
            drive();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
